// File: rtl/muldiv_pkg.sv
// Shared definitions for the MIPS HI/LO multiply/divide unit:
// funct codes of the HI/LO instruction group and the FSM state type.
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned bit-serial datapath: shift-add multiply / restoring divide.
// Ports: i_load latches magnitudes, i_step runs one iteration,
//        o_acc = product or {0,remainder}, o_sr = quotient, o_last = final step.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_a_mag,
    input  logic [WIDTH-1:0]   i_b_mag,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0]   o_sr,
    output logic               o_last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic               r_div;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;

    // Multiply: add multiplicand into the upper half, then shift the
    // whole product right so retired multiplier bits fall into the low half.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    assign w_mul_next = r_sr[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide: a wrap into the top bit of the W+1 bit difference means
    // the trial subtraction went negative, so the remainder is restored.
    assign w_rem_sh   = {r_acc[WIDTH-1:0], r_sr[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_sr  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_div <= i_is_div;
            r_acc <= '0;
            r_cnt <= '0;
            if (i_is_div) begin
                r_sr <= i_a_mag;
                r_b  <= i_b_mag;
            end else begin
                r_sr <= i_b_mag;
                r_b  <= i_a_mag;
            end
        end else if (i_step) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_div) begin
                r_acc <= {{WIDTH{1'b0}}, w_rem_next};
                r_sr  <= {r_sr[WIDTH-2:0], w_qbit};
            end else begin
                r_acc <= w_mul_next;
                r_sr  <= {1'b0, r_sr[WIDTH-1:1]};
            end
        end
    end

    assign o_acc  = r_acc;
    assign o_sr   = r_sr;
    assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO unit: MULT/MULTU/DIV/DIVU iterative, MTHI/MTLO, MFHI/MFLO.
// Ports: clk, rst, start, func_field, A, B in; busy, done, div_by_zero,
//        hi, lo, result (combinational MFHI/MFLO read) out.
module mips_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       func_field,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    state_t r_state;
    state_t w_next;

    logic             r_div;
    logic             r_neg_p;
    logic             r_neg_r;
    logic             r_bzero;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz;

    logic             w_is_mul;
    logic             w_is_div;
    logic             w_sgn_op;
    logic             w_accept;
    logic             w_idle;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [2*WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_sr;
    logic [WIDTH-1:0] w_rem;
    logic             w_last;
    logic [WIDTH-1:0] w_fin_hi;
    logic [WIDTH-1:0] w_fin_lo;

    assign w_is_mul = (func_field == FUNCT_MULT) || (func_field == FUNCT_MULTU);
    assign w_is_div = (func_field == FUNCT_DIV)  || (func_field == FUNCT_DIVU);
    assign w_sgn_op = (func_field == FUNCT_MULT) || (func_field == FUNCT_DIV);
    assign w_idle   = (r_state == IDLE);
    assign w_accept = start && w_idle && (w_is_mul || w_is_div);

    // Most-negative negates to itself, which is its correct unsigned magnitude.
    assign w_a_neg  = w_sgn_op && A[WIDTH-1];
    assign w_b_neg  = w_sgn_op && B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -A : A;
    assign w_b_mag  = w_b_neg ? -B : B;

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_step   (r_state == RUN),
        .i_is_div (w_is_div),
        .i_a_mag  (w_a_mag),
        .i_b_mag  (w_b_mag),
        .o_acc    (w_acc),
        .o_sr     (w_sr),
        .o_last   (w_last)
    );

    assign w_rem = w_acc[WIDTH-1:0];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (w_last) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Sign fixup applied to the magnitude result in FIN.
    always_comb begin
        w_fin_hi = r_hi;
        w_fin_lo = r_lo;
        if (r_div) begin
            if (r_bzero) begin
                w_fin_hi = r_a;
                w_fin_lo = '1;
            end else begin
                w_fin_lo = r_neg_p ? -w_sr : w_sr;
                w_fin_hi = r_neg_r ? -w_rem : w_rem;
            end
        end else begin
            {w_fin_hi, w_fin_lo} = r_neg_p ? -w_acc : w_acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_div   <= 1'b0;
            r_neg_p <= 1'b0;
            r_neg_r <= 1'b0;
            r_bzero <= 1'b0;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == FIN);
            r_dbz   <= (r_state == FIN) && r_div && r_bzero;
            if (w_accept) begin
                r_div   <= w_is_div;
                r_neg_p <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_bzero <= (B == '0);
                r_a     <= A;
            end
            if (r_state == FIN) begin
                r_hi <= w_fin_hi;
                r_lo <= w_fin_lo;
            end else if (start && w_idle) begin
                if (func_field == FUNCT_MTHI) r_hi <= A;
                if (func_field == FUNCT_MTLO) r_lo <= A;
            end
        end
    end

    assign busy        = !w_idle;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign result      = (func_field == FUNCT_MFHI) ? r_hi :
                         (func_field == FUNCT_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomised bench for mips_muldiv_unit (WIDTH=32) against an
// arithmetic reference model of the HI/LO instruction group.
module tb_mips_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  func_field;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .func_field  (func_field),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [5:0] f,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] eh,
                                  output logic [31:0] el,
                                  output bit ez);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ez = 1'b0;
        eh = '0;
        el = '0;
        if (f == FUNCT_MULT) begin
            p = sa * sb;
            {eh, el} = p;
        end else if (f == FUNCT_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            {eh, el} = p;
        end else if (b == 32'd0) begin
            eh = a;
            el = '1;
            ez = 1'b1;
        end else if (f == FUNCT_DIV) begin
            q = sa / sb;
            r = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endfunction

    // Called on a falling edge; returns on the falling edge of the done cycle.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit intrude);
        logic [31:0] eh, el;
        bit ez;
        int e, nb;
        model(f, a, b, eh, el, ez);
        start = 1'b1;
        func_field = f;
        A = a;
        B = b;
        @(negedge clk);
        start = 1'b0;
        e = 0;
        nb = 0;
        while (!done && e < 60) begin
            if (busy) nb++;
            if (e == 3) begin
                func_field = FUNCT_MFLO;
                #1;
                chk("busy_rd", result, m_lo);
            end
            if (e == 5 && intrude) begin
                start = 1'b1;
                func_field = FUNCT_MULT;
                A = $urandom;
                B = $urandom;
            end
            if (e == 6) start = 1'b0;
            @(negedge clk);
            e++;
        end
        chk("latency", e, 33);
        chk("busy_cyc", nb, 33);
        chk("busy_done", busy, 0);
        chk("done", done, 1);
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("dbz", div_by_zero, ez);
        m_hi = eh;
        m_lo = el;
        func_field = FUNCT_MFHI;
        #1;
        chk("mfhi", result, m_hi);
        func_field = FUNCT_MFLO;
        #1;
        chk("mflo", result, m_lo);
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_hi", hi, m_hi);
        chk("idle_lo", lo, m_lo);
    endtask

    task automatic single(input logic [5:0] f, input logic [31:0] a);
        start = 1'b1;
        func_field = f;
        A = a;
        B = $urandom;
        @(negedge clk);
        start = 1'b0;
        if (f == FUNCT_MTHI) m_hi = a;
        if (f == FUNCT_MTLO) m_lo = a;
        chk("mt_busy", busy, 0);
        chk("mt_hi", hi, m_hi);
        chk("mt_lo", lo, m_lo);
    endtask

    initial begin
        bit saw;
        logic [5:0] f;
        logic [31:0] a, b;
        logic [5:0] ops [4];
        ops[0] = FUNCT_MULT;
        ops[1] = FUNCT_MULTU;
        ops[2] = FUNCT_DIV;
        ops[3] = FUNCT_DIVU;
        rst = 1'b1;
        start = 1'b0;
        func_field = 6'h00;
        A = '0;
        B = '0;
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(FUNCT_MULTU, 32'h00002222, 32'h00001111, 1'b0);
        idle_check();
        do_op(FUNCT_MULT, 32'hFFFFFFFF, 32'h00000005, 1'b0);
        do_op(FUNCT_MULTU, 32'hFFFFFFFF, 32'h00000005, 1'b0);
        do_op(FUNCT_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        do_op(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        do_op(FUNCT_DIVU, 32'h00005555, 32'h00000000, 1'b0);
        do_op(FUNCT_DIV, 32'h80000000, 32'h00000000, 1'b0);
        idle_check();

        single(FUNCT_MTLO, 32'h00001234);
        func_field = FUNCT_MFLO;
        #1;
        chk("mtlo_rd", result, 32'h00001234);
        single(FUNCT_MTHI, 32'hCAFEF00D);
        single(FUNCT_MFHI, 32'h11111111);
        single(6'h20, 32'h22222222);
        idle_check();

        @(negedge clk);
        do_op(FUNCT_MULT, 32'h00000007, 32'hFFFFFFFD, 1'b1);
        idle_check();

        start = 1'b1;
        func_field = FUNCT_DIV;
        A = $urandom;
        B = $urandom | 32'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_done", done, 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("no_done", saw, 0);
        do_op(FUNCT_MULTU, $urandom, $urandom, 1'b0);

        for (int i = 0; i < 40; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = b & 32'h0000000F;
                3: a = a & 32'h000000FF;
                default: ;
            endcase
            do_op(f, a, b, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_check();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
